// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared definitions for the ZBT frame store: raster geometry defaults,
// camera (RGB666) and display (RGB888) pixel types, the frame-store address
// packing used by both the capture-side writer and the display-side reader,
// and the 6-to-8 bit colour expansion.
// ---------------------------------------------------------------------------
package vram_pkg;

  localparam int H_TOTAL  = 1344;  // raster columns per line, multiple of 4
  localparam int V_TOTAL  = 806;   // raster lines per frame
  localparam int H_ACTIVE = 1024;  // visible columns
  localparam int V_ACTIVE = 768;   // visible lines

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb666_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Frame-store address: camera row y, field f, word x within the row.
  function automatic logic [18:0] vram_pack_addr(input logic [8:0] y,
                                                 input logic       f,
                                                 input logic [7:0] x);
    return {1'b0, y, f, x};
  endfunction

  // Replicate the top bits so full-scale 6-bit maps to full-scale 8-bit.
  function automatic rgb888_t expand_666(input rgb666_t c);
    rgb888_t o;
    o.r = {c.r, c.r[5:4]};
    o.g = {c.g, c.g[5:4]};
    o.b = {c.b, c.b[5:4]};
    return o;
  endfunction

endpackage

// File: rtl/vram_addr_gen.sv
// ---------------------------------------------------------------------------
// vram_addr_gen
// Forecasts the ZBT read address one word ahead of the raster. On every
// column with hcount[1:0]==0 the address of the next word is registered:
// the following word of the current line, or word 0 of the next line (with
// frame wrap) at the last fetch slot of the line.
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   hcount     in   raster column
//   vcount     in   raster line
//   vram_addr  out  registered ZBT read address (resets to 0)
// ---------------------------------------------------------------------------
module vram_addr_gen
  import vram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [18:0] vram_addr
);

  logic        last_fetch;
  logic [9:0]  line_nxt;
  logic [9:0]  line_sel;
  logic [7:0]  word_sel;
  logic [18:0] addr_nxt;

  always_comb begin
    last_fetch = (hcount == 11'(H_TOTAL - 4));
    line_nxt   = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    line_sel   = vcount;
    // 8-bit word index wraps past x=255; those words are fetched but the
    // columns that use them are blanked.
    word_sel   = hcount[9:2] + 8'd1;
    if (last_fetch) begin
      line_sel = line_nxt;
      word_sel = 8'd0;
    end
    addr_nxt = vram_pack_addr(line_sel[9:1], line_sel[0], word_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr <= 19'd0;
    end else if (hcount[1:0] == 2'b00) begin
      vram_addr <= addr_nxt;
    end
  end

endmodule

// File: rtl/vram_rgb_fetch.sv
// ---------------------------------------------------------------------------
// vram_rgb_fetch
// Display-side reader of the ZBT frame store. Issues read addresses ahead of
// the XGA raster, captures each 36-bit word after the 2-cycle ZBT latency and
// shows its two RGB666 pixels (left = [35:18], right = [17:0]) each twice
// horizontally, expanded to RGB888.
//
// The 4-column fetch/capture cycle is decoded directly from hcount[1:0]:
//   00  address of the next word is registered
//   11  read data for the current word group is captured into cur_word
//
// Optional feature: define VRAM_TEST_PATTERN_EN to enable 8 vertical colour
// bars (selected by test_en) in place of frame-store data. Fetching and
// latency are unaffected; blanking still forces black.
//
// Ports
//   clk             in   pixel clock (65 MHz)
//   rst_n           in   asynchronous active-low reset
//   hcount          in   raster column
//   vcount          in   raster line
//   blank           in   raster blanking, aligned with hcount
//   test_en         in   colour-bar select (VRAM_TEST_PATTERN_EN only)
//   vram_read_data  in   ZBT read data, valid 2 clk after the address
//   vram_addr       out  registered ZBT read address
//   pixel           out  {R8,G8,B8}, registered, 1 clk after hcount
//   blank_out       out  blank delayed to align with pixel
// ---------------------------------------------------------------------------
module vram_rgb_fetch
  import vram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        blank,
  input  logic        test_en,
  input  logic [35:0] vram_read_data,
  output logic [18:0] vram_addr,
  output logic [23:0] pixel,
  output logic        blank_out
);

  logic [35:0] cur_word;
  rgb666_t     cam_px;
  rgb888_t     src_px;

  vram_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .vram_addr (vram_addr)
  );

  // Data requested at phase 00 is on the bus during phase 11; holding it in
  // cur_word covers the next four columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_word <= 36'd0;
    end else if (hcount[1:0] == 2'b11) begin
      cur_word <= vram_read_data;
    end
  end

`ifdef VRAM_TEST_PATTERN_EN
  rgb888_t bar_px;

  always_comb begin
    case (hcount[9:7])
      3'd0:    bar_px = 24'hFFFFFF;  // white
      3'd1:    bar_px = 24'hFFFF00;  // yellow
      3'd2:    bar_px = 24'h00FFFF;  // cyan
      3'd3:    bar_px = 24'h00FF00;  // green
      3'd4:    bar_px = 24'hFF00FF;  // magenta
      3'd5:    bar_px = 24'hFF0000;  // red
      3'd6:    bar_px = 24'h0000FF;  // blue
      default: bar_px = 24'h000000;  // black
    endcase
  end
`else
  logic unused_test_en;
  assign unused_test_en = test_en;
`endif

  always_comb begin
    cam_px = hcount[1] ? rgb666_t'(cur_word[17:0]) : rgb666_t'(cur_word[35:18]);
    src_px = expand_666(cam_px);
`ifdef VRAM_TEST_PATTERN_EN
    if (test_en) begin
      src_px = bar_px;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel     <= 24'd0;
      blank_out <= 1'b1;
    end else begin
      pixel     <= blank ? 24'd0 : src_px;
      blank_out <= blank;
    end
  end

endmodule
